assoc_cache: RTL

- Parametrised N-way set-associative, write-back, write-allocate unified cache for the LC-3b core.
- Sits between the CPU memory port (16-bit words, byte enables) and physical memory (128-bit lines).
- Successor to the fixed 2-way datapath. Adds a configurable way count and set count, tree pseudo-LRU replacement, and an integrated miss-handling controller (writeback, then fill).

---
 rtl/assoc_cache.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - N-way set-associative write-back write-allocate cache with tree PLRU
module assoc_cache #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = 12 - SET_BITS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    logic [1:0]       state;
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [2:0]       plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [127:0]     data_q  [WAYS][SETS];

    logic [WAY_W-1:0]    victim_q;
    logic [SET_BITS-1:0] miss_set_q;
    logic [TAG_W-1:0]    miss_tag_q;

    logic [TAG_W-1:0]    req_tag;
    logic [SET_BITS-1:0] req_set;
    logic [2:0]          req_word;
    logic                req;
    logic                unused_addr_bit;

    assign req_tag         = mem_address[15:4+SET_BITS];
    assign req_set         = mem_address[3+SET_BITS:4];
    assign req_word        = mem_address[3:1];
    assign req             = mem_read | mem_write;
    assign unused_addr_bit = mem_address[0];

    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way;
    logic [127:0]     hit_line;
    logic             hit;

    // Tag compare across all ways of the indexed set
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[w][req_set] == req_tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
                hit_line   = data_q[w][req_set];
            end
        end
    end

    assign hit = |hit_vec;

    logic [2:0]       plru_cur;
    logic [2:0]       plru_upd;
    logic [WAY_W-1:0] victim;
    logic             victim_dirty;

    assign plru_cur = plru_q[req_set];

    // Victim choice: lowest invalid way wins, otherwise follow the PLRU tree
    always_comb begin
        victim = '0;
        if (WAYS == 4) begin
            victim = WAY_W'(plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]});
        end else if (WAYS == 2) begin
            victim = WAY_W'(plru_cur[0]);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                victim = WAY_W'(w);
            end
        end
        victim_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == victim) begin
                victim_dirty = valid_q[req_set][w] && dirty_q[req_set][w];
            end
        end
    end

    // PLRU bits after a hit: every tree node on the path points away from the hit way
    always_comb begin
        plru_upd = plru_cur;
        if (WAYS == 2) begin
            plru_upd[0] = ~hit_way[0];
        end else if (WAYS == 4) begin
            plru_upd[0] = ~hit_way[WAY_W-1];
            if (hit_way[WAY_W-1]) begin
                plru_upd[2] = ~hit_way[0];
            end else begin
                plru_upd[1] = ~hit_way[0];
            end
        end
    end

    logic [127:0] wr_line;
    logic         do_write_hit;

    // Byte-merge of the CPU write word into the hit line
    always_comb begin
        wr_line = hit_line;
        if (mem_byte_enable[0]) begin
            wr_line[{req_word, 4'b0000} +: 8] = mem_wdata[7:0];
        end
        if (mem_byte_enable[1]) begin
            wr_line[{req_word, 4'b1000} +: 8] = mem_wdata[15:8];
        end
    end

    assign mem_resp     = (state == ST_IDLE) && req && hit;
    assign mem_rdata    = mem_resp ? hit_line[{req_word, 4'b0000} +: 16] : 16'h0000;
    assign do_write_hit = mem_resp && mem_write && (mem_byte_enable != 2'b00);

    logic [TAG_W-1:0] vic_tag;
    logic [127:0]     vic_line;

    // Registered victim's tag and line, used as the writeback source
    always_comb begin
        vic_tag  = '0;
        vic_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == victim_q) begin
                vic_tag  = tag_q[w][miss_set_q];
                vic_line = data_q[w][miss_set_q];
            end
        end
    end

    assign pmem_write   = (state == ST_WRITEBACK);
    assign pmem_read    = (state == ST_FILL);
    assign pmem_wdata   = pmem_write ? vic_line : 128'h0;
    assign pmem_address = pmem_write ? {vic_tag, miss_set_q, 4'b0000} :
                          pmem_read  ? {miss_tag_q, miss_set_q, 4'b0000} : 16'h0000;

    // Miss controller plus valid/dirty/PLRU bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            victim_q   <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && hit) begin
                        plru_q[req_set] <= plru_upd;
                        if (do_write_hit) begin
                            dirty_q[req_set][hit_way] <= 1'b1;
                        end
                    end else if (req) begin
                        victim_q   <= victim;
                        miss_set_q <= req_set;
                        miss_tag_q <= req_tag;
                        state      <= victim_dirty ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_q[miss_set_q][victim_q] <= 1'b0;
                        state                         <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (pmem_resp) begin
                        valid_q[miss_set_q][victim_q] <= 1'b1;
                        dirty_q[miss_set_q][victim_q] <= 1'b0;
                        state                         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays: line install on fill, byte merge on write hit
    always_ff @(posedge clk) begin
        if ((state == ST_FILL) && pmem_resp) begin
            tag_q[victim_q][miss_set_q]  <= miss_tag_q;
            data_q[victim_q][miss_set_q] <= pmem_rdata;
        end else if (do_write_hit) begin
            data_q[hit_way][req_set] <= wr_line;
        end
    end

    hit_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(hit_vec));

endmodule
